// File: rtl/nn_pkg.sv
// ----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neural-network output stage.
//   - argmax_state_t : FSM state encoding for argmax_classifier
//   - NN_NEURON_NB   : default number of output-layer scores
//   - NN_WIDTH_OUT   : default bit width of each signed score
//   - NN_IDX_W       : default class index width
// ----------------------------------------------------------------------------
package nn_pkg;

    localparam int NN_NEURON_NB = 10;
    localparam int NN_WIDTH_OUT = 32;
    localparam int NN_IDX_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } argmax_state_t;

endpackage : nn_pkg

// File: rtl/argmax_cmp.sv
// ----------------------------------------------------------------------------
// argmax_cmp
// Combinational signed compare-and-select for one argmax step. The candidate
// replaces the current best only when strictly greater, so on a tie the
// earlier (lower) index is kept.
// Ports:
//   best      : current best score (signed)
//   best_idx  : index of current best score
//   candidate : score being examined (signed)
//   cand_idx  : index of the candidate
//   new_best  : best score after this step
//   new_idx   : index of new_best
// ----------------------------------------------------------------------------
module argmax_cmp #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 4
) (
    input  logic signed [WIDTH-1:0] best,
    input  logic        [IDX_W-1:0] best_idx,
    input  logic signed [WIDTH-1:0] candidate,
    input  logic        [IDX_W-1:0] cand_idx,
    output logic signed [WIDTH-1:0] new_best,
    output logic        [IDX_W-1:0] new_idx
);

    // Strictly-greater select; ties keep the incumbent.
    always_comb begin
        new_best = best;
        new_idx  = best_idx;
        if (candidate > best) begin
            new_best = candidate;
            new_idx  = cand_idx;
        end else begin
            new_best = best;
            new_idx  = best_idx;
        end
    end

endmodule : argmax_cmp

// File: rtl/argmax_classifier.sv
// ----------------------------------------------------------------------------
// argmax_classifier
// Sequential argmax over NEURON_NB signed scores. A rising edge on start
// (seen while idle) snapshots all scores, then one score per cycle is
// compared against the running best. The winning index is published with a
// one-cycle class_valid pulse NEURON_NB cycles after the start edge.
//
// Parameters:
//   NEURON_NB : number of scores (>= 2)
//   WIDTH_OUT : width of each signed score
//   IDX_W     : class index width (2**IDX_W >= NEURON_NB)
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   start       : level input; its rising edge launches a scan
//   scores      : flattened scores, score i at [(i+1)*WIDTH_OUT-1 -: WIDTH_OUT]
//   busy        : high while scanning or publishing
//   class_idx   : index of the winning score, held between results
//   max_score   : winning score (only when ARGMAX_SCORE_EN is defined)
//   class_valid : one-cycle pulse marking a new class_idx
//
// Build option: define ARGMAX_SCORE_EN to add the max_score output.
// ----------------------------------------------------------------------------
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int NEURON_NB = NN_NEURON_NB,
    parameter int WIDTH_OUT = NN_WIDTH_OUT,
    parameter int IDX_W     = NN_IDX_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic signed [WIDTH_OUT*NEURON_NB-1:0] scores,
    output logic                                 busy,
    output logic        [IDX_W-1:0]              class_idx,
`ifdef ARGMAX_SCORE_EN
    output logic signed [WIDTH_OUT-1:0]          max_score,
`endif
    output logic                                 class_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_NB - 1);

    argmax_state_t                        state_r;
    logic                                 start_r;
    logic signed [WIDTH_OUT*NEURON_NB-1:0] scores_r;
    logic        [IDX_W-1:0]              cnt_r;
    logic signed [WIDTH_OUT-1:0]          best_r;
    logic        [IDX_W-1:0]              best_idx_r;
    logic                                 busy_r;
    logic        [IDX_W-1:0]              class_idx_r;
    logic                                 class_valid_r;
`ifdef ARGMAX_SCORE_EN
    logic signed [WIDTH_OUT-1:0]          max_score_r;
`endif

    logic                                 start_edge_s;
    logic signed [WIDTH_OUT-1:0]          cand_s;
    logic signed [WIDTH_OUT-1:0]          new_best_s;
    logic        [IDX_W-1:0]              new_idx_s;

    assign start_edge_s = start & ~start_r;

    // Select the captured score addressed by the scan counter.
    always_comb begin
        cand_s = {WIDTH_OUT{1'b0}};
        for (int i = 0; i < NEURON_NB; i++) begin
            if (cnt_r == i[IDX_W-1:0]) begin
                cand_s = scores_r[i*WIDTH_OUT +: WIDTH_OUT];
            end else begin
                cand_s = cand_s;
            end
        end
    end

    argmax_cmp #(
        .WIDTH (WIDTH_OUT),
        .IDX_W (IDX_W)
    ) u_cmp (
        .best      (best_r),
        .best_idx  (best_idx_r),
        .candidate (cand_s),
        .cand_idx  (cnt_r),
        .new_best  (new_best_s),
        .new_idx   (new_idx_s)
    );

    // Control FSM with capture register, running best and registered outputs.
    // start_r resets to 1 so a start held high through reset is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            start_r       <= 1'b1;
            scores_r      <= {(WIDTH_OUT*NEURON_NB){1'b0}};
            cnt_r         <= {IDX_W{1'b0}};
            best_r        <= {WIDTH_OUT{1'b0}};
            best_idx_r    <= {IDX_W{1'b0}};
            busy_r        <= 1'b0;
            class_idx_r   <= {IDX_W{1'b0}};
            class_valid_r <= 1'b0;
`ifdef ARGMAX_SCORE_EN
            max_score_r   <= {WIDTH_OUT{1'b0}};
`endif
        end else begin
            start_r       <= start;
            class_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        scores_r   <= scores;
                        best_r     <= scores[WIDTH_OUT-1:0];
                        best_idx_r <= {IDX_W{1'b0}};
                        cnt_r      <= IDX_W'(1);
                        busy_r     <= 1'b1;
                        state_r    <= ST_SCAN;
                    end else begin
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    best_r     <= new_best_s;
                    best_idx_r <= new_idx_s;
                    cnt_r      <= cnt_r + IDX_W'(1);
                    busy_r     <= 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    class_idx_r   <= best_idx_r;
`ifdef ARGMAX_SCORE_EN
                    max_score_r   <= best_r;
`endif
                    class_valid_r <= 1'b1;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign class_idx   = class_idx_r;
    assign class_valid = class_valid_r;
`ifdef ARGMAX_SCORE_EN
    assign max_score   = max_score_r;
`endif

endmodule : argmax_classifier

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter NEURON_NB, default 10, number of output-layer scores scanned.
REQ-002 SHALL have parameter WIDTH_OUT, default 32, bit width of each signed score.
REQ-003 SHALL have parameter IDX_W, default 4, class index width; legal only if 2**IDX_W >= NEURON_NB and NEURON_NB >= 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port start, input, 1, level signal driven by the final dense layer's done output.
REQ-007 SHALL have port scores, input, signed WIDTH_OUT*NEURON_NB, flattened scores; score i at bits [(i+1)*WIDTH_OUT-1 -: WIDTH_OUT].
REQ-008 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-009 SHALL have port class_idx, output, IDX_W, index of the winning score.
REQ-010 SHALL have port class_valid, output, 1, one-cycle pulse marking a new class_idx.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-012 SHALL register start each cycle and detect a start edge as start=1 with the registered value 0.
REQ-013 In IDLE, a start edge SHALL capture all of scores into an internal register, load best=score0, best_idx=0, cnt=1, and move to SCAN.
REQ-014 In SCAN, each cycle SHALL compare captured score[cnt] signed against best and replace best/best_idx only if strictly greater; ties keep the lower index.
REQ-015 In SCAN, cnt SHALL increment each cycle; the compare at cnt=NEURON_NB-1 SHALL be the last, and the state SHALL then move to DONE.
REQ-016 In DONE, the block SHALL drive class_idx=best_idx and pulse class_valid for exactly one cycle, then return to IDLE.
REQ-017 class_valid SHALL rise exactly NEURON_NB cycles after the cycle in which the start edge is sampled.
REQ-018 busy SHALL be high in SCAN and DONE and low in IDLE.
REQ-019 Start edges sampled outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-020 Changes on scores after capture SHALL NOT affect the current result.
REQ-021 class_idx SHALL hold its value between results.
REQ-022 A start edge in the same cycle that DONE returns to IDLE SHALL be ignored, because the FSM is not yet in IDLE.

Reset
REQ-023 While reset=0, the FSM SHALL be IDLE; busy, class_valid, class_idx, cnt, best, best_idx and the capture register SHALL be 0.
REQ-024 While reset=0, the registered start SHALL be 1, so a start held high across reset release is not an edge.
REQ-025 Reset asserted mid-scan SHALL abort it immediately with no class_valid pulse.

Configuration
REQ-026 With macro ARGMAX_SCORE_EN defined, the block SHALL add output max_score, signed WIDTH_OUT bits, reset to 0, updated together with class_idx to the winning score, and held between results.
REQ-027 Without ARGMAX_SCORE_EN, the max_score port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 The FSM state encodings and the default NEURON_NB, WIDTH_OUT and IDX_W constants SHALL live in the shared package nn_pkg.
REQ-029 The signed strictly-greater compare-and-select SHALL be the sub-module argmax_cmp (inputs: best, best_idx, candidate, cand_idx; outputs: new best, new index).

Verification
REQ-030 Scores 0..9 = {5,-3,7,2,100,0,-1,99,4,6}, start edge -> class_valid 10 cycles later with class_idx=4 (max_score=100 when enabled).
REQ-031 All scores = -2147483648 -> class_idx=0; score9=-2147483647, others minimum -> class_idx=9.
REQ-032 Tie: scores 2 and 6 both =50, rest <50 -> class_idx=2.
REQ-033 Second start edge 3 cycles into a scan, and scores changed after capture -> exactly one class_valid pulse, with the result from the captured scores.
REQ-034 Reset asserted 5 cycles into a scan -> busy=0, class_idx=0, no class_valid; start held high across reset release -> no scan until start falls and rises again.
